// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants and state encoding for the 8-way round-robin bus arbiter
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin picker: first set req bit at or after start, wrapping
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   enc;

    always_comb begin
        // rot[i] = req[(i + start) mod 8], so the lowest set bit of rot is the winner
        dbl   = {req, req};
        rot   = N_REQ'(dbl >> start);
        found = |rot;
        enc   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = SEL_W'(i);
            end
        end
        idx = enc + start;
    end

endmodule

// File: rtl/rr_bus_arbiter8.sv
// rtl/rr_bus_arbiter8.sv - round-robin arbiter for 8 requesters on a shared 16-bit bus with burst limit
module rr_bus_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             out_valid,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

    logic [0:0]       state;
    logic [SEL_W-1:0] last;
    logic [CNT_W-1:0] beat_cnt;
    logic             found;
    logic [SEL_W-1:0] pick;
    logic             owner_req;
    logic             transfer;
    logic             rel;

    rr_pick8 u_pick (
        .req   (req),
        .start (last + SEL_W'(1)),
        .found (found),
        .idx   (pick)
    );

    assign busy      = (state == ST_BUSY);
    assign owner_req = req[sel];
    // Gated by rst so a burst aborted by reset never reports a transfer in that cycle
    assign out_valid = busy & owner_req & ~rst;
    assign transfer  = out_valid & out_ready;
    assign ack       = transfer ? gnt : '0;
    assign rel       = (transfer && (beat_cnt == BEAT_LAST)) || !owner_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            last     <= SEL_W'(N_REQ - 1);
            beat_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (found) begin
                state    <= ST_BUSY;
                sel      <= pick;
                gnt      <= onehot(pick);
                last     <= pick;
                beat_cnt <= '0;
            end
        end else begin
            if (rel) begin
                // Re-arbitrate in the release cycle; the current owner is searched last
                if (found) begin
                    sel      <= pick;
                    gnt      <= onehot(pick);
                    last     <= pick;
                    beat_cnt <= '0;
                end else begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            end else if (transfer) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// tb/tb_rr_bus_arbiter8.sv - self-checking bench for rr_bus_arbiter8 against a cycle-level reference model
module tb_rr_bus_arbiter8;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out_valid;
    logic [7:0] ack;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_busy;
    int m_owner;
    int m_last;
    int m_sel;
    int m_beats;
    int ack_count [8];

    rr_bus_arbiter8 #(.MAX_BURST(MB), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick_ref(input logic [7:0] r, input int from_last);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (from_last + k) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) ack_count[i] = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model mid-cycle, then advance the model
    task automatic cyc(input logic [7:0] r, input logic rdy, input logic rs);
        logic       ev;
        logic [7:0] eg;
        logic [7:0] ea;
        int         p;
        req       = r;
        out_ready = rdy;
        rst       = rs;
        @(negedge clk);
        eg = m_busy ? 8'(1 << m_owner) : 8'h00;
        ev = !rs && m_busy && r[m_owner];
        ea = (ev && rdy) ? eg : 8'h00;
        check("sel", 8'(sel), 8'(m_sel));
        check("gnt", gnt, eg);
        check("out_valid", 8'(out_valid), 8'(ev));
        check("ack", ack, ea);
        check("busy", 8'(busy), 8'(m_busy));
        if (ea != 8'h00) ack_count[m_owner]++;
        @(posedge clk);
        #1;
        if (rs) begin
            m_busy = 0; m_owner = 0; m_sel = 0; m_last = 7; m_beats = 0;
        end else if (!m_busy) begin
            p = pick_ref(r, m_last);
            if (p >= 0) begin
                m_busy = 1; m_owner = p; m_sel = p; m_last = p; m_beats = 0;
            end
        end else begin
            if (ev && rdy) m_beats++;
            if (!ev || m_beats == MB) begin
                p = pick_ref(r, m_last);
                if (p >= 0) begin
                    m_owner = p; m_sel = p; m_last = p; m_beats = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] rr;
        req = 8'h00; out_ready = 1'b0; rst = 1'b1;
        m_busy = 0; m_owner = 0; m_sel = 0; m_last = 7; m_beats = 0;
        clear_counts();
        @(posedge clk);
        #1;

        // Reset state and a single requester re-granted to itself at the burst limit
        cyc(8'h00, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 9; i++) cyc(8'h01, 1'b1, 1'b0);
        check("self_regrant_acks", 8'(ack_count[0]), 8'd8);

        // All requesting: each owner gets exactly MB beats in rotation
        cyc(8'h00, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 1 + 8 * MB; i++) cyc(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) check("rotate_acks", 8'(ack_count[i]), 8'(MB));

        // Stalled consumer freezes the burst, then handover from 3 to 7
        cyc(8'h00, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 6; i++) cyc(8'h88, 1'b0, 1'b0);
        for (int i = 0; i < MB; i++) cyc(8'h88, 1'b1, 1'b0);
        check("stall_acks3", 8'(ack_count[3]), 8'(MB));
        cyc(8'h88, 1'b0, 1'b0);
        check("handover_gnt", gnt, 8'h80);
        check("handover_sel", 8'(sel), 8'd7);

        // Owner withdraws: handover to 1, then idle once nobody requests
        cyc(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(8'h20, 1'b1, 1'b0);
        cyc(8'h02, 1'b1, 1'b0);
        cyc(8'h02, 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);

        // Reset mid-burst, then pointer restarts at index 0
        cyc(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(8'h40, 1'b1, 1'b0);
        cyc(8'h40, 1'b1, 1'b1);
        cyc(8'h41, 1'b1, 1'b0);
        cyc(8'h41, 1'b1, 1'b0);
        check("post_reset_gnt", gnt, 8'h01);

        // Single requester with a toggling consumer
        cyc(8'h00, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 21; i++) cyc(8'h04, 1'(i % 2), 1'b0);
        check("toggle_acks", 8'(ack_count[2]), 8'd10);

        // Randomised traffic with sticky requests and occasional reset
        rr = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rr = rr ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) rr = 8'($urandom);
            cyc(rr, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter8.md
Name: rr_bus_arbiter8

Overview:
- Round-robin arbiter for 8 requesters sharing one 16-bit bus through an external 8:1 16-bit select mux.
- Drives the mux select and a one-hot grant, and handles a valid/ready handshake toward the bus consumer.
- Issues a per-requester ack on each transferred word.
- Bounds each ownership to MAX_BURST beats to prevent starvation. Sits between the register/ALU sources and the shared writeback bus.

Parameters:
- MAX_BURST, 4, max words transferred per grant before forced re-arbitration (1..256).
- CNT_W, 8, width of the beat counter; must hold MAX_BURST-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  req[i]=1: requester i has a word on mux input Ai.
- out_ready  input  1  bus consumer accepts the current word.
- sel  output  3  registered mux select, binary index of the owner.
- gnt  output  8  registered one-hot grant; all zero when idle.
- out_valid  output  1  word on the mux output is valid.
- ack  output  8  one-hot pulse: word from requester i transferred this cycle.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset: on rst=1 at a clock edge:
  - state=IDLE, gnt=0, sel=0, beat_cnt=0.
  - last pointer=7, so the first search starts at index 0.
  - out_valid=0, ack=0, busy=0.
  - Reset mid-burst aborts the burst; no ack in the reset cycle.
- States: IDLE, BUSY.
- Pick function: the first set bit of req, searching from (last+1) mod 8 upward with wrap to 0. The most recent owner has lowest priority.
- IDLE:
  - If req!=0 at edge N, then from edge N+1: state=BUSY, sel=pick, gnt=1<<pick, last=pick, beat_cnt=0.
  - Latency is 1 cycle from req to grant.
  - If req==0, stay IDLE.
- BUSY:
  - out_valid = req[sel] (combinational).
  - Transfer = out_valid & out_ready.
  - ack = transfer ? gnt : 0 (combinational).
  - busy = 1.
- Release conditions (evaluated each BUSY cycle):
  - (a) transfer and beat_cnt==MAX_BURST-1;
  - (b) req[sel]==0, meaning the owner withdrew.
- On release, re-arbitrate in the same cycle with no bubble:
  - If pick over req (owner still eligible at lowest priority) finds a requester, load the new sel/gnt/last, beat_cnt=0, stay BUSY.
  - If no requester is found, go to IDLE, gnt=0, sel holds its last value.
- Transfer without release: beat_cnt+1.
- out_ready=0: hold state, beat_cnt frozen, no timeout.
- Single requester hitting the burst limit: re-granted to itself with beat_cnt=0, no idle cycle, continuous acks.
- Owner dropping req in the same cycle a transfer would occur: no transfer (out_valid=0), release via (b).
- req of non-owners changing mid-burst: no effect until release.
- MAX_BURST=1: re-arbitrate after every beat.
- gnt is always one-hot or zero. ack is never asserted outside BUSY.

Decomposition:
- Shared package rr_arb_pkg holds:
  - constants N_REQ=8, SEL_W=3;
  - state encoding ST_IDLE=1'b0, ST_BUSY=1'b1.
- One sub-module, rr_pick8: a combinational round-robin priority picker.
  - Inputs: req[7:0], start[2:0].
  - Outputs: found, idx[2:0].
  - Implemented by rotate, priority-encode, rotate back.

Test Plan:
- Reset, then req=8'b0000_0001 with out_ready=1 → gnt=0x01 and sel=0 one cycle later; ack[0] pulses 4 cycles; beat 4 causes a self re-grant with no idle cycle.
- req=0xFF held, out_ready=1, MAX_BURST=4 → owners rotate 0,1,2,...,7,0, each exactly 4 acks; sel steps 0→1→2 with zero-bubble handover.
- Owner 3 granted with req=0x88, out_ready=0 for 5 cycles → sel=3, no ack, beat_cnt frozen. Then out_ready=1 → 4 acks to 3, then gnt=0x80, sel=7.
- Owner 5 drops req after 2 beats while req[1]=1 → next cycle gnt=0x02, sel=1. With no other request → IDLE, gnt=0, busy=0.
- rst=1 asserted mid-burst (owner 6, beat 2) → next edge gnt=0, out_valid=0, busy=0. After release with req=0x41, grant goes to 0 (pointer reset to 7).
- Single requester 2 held continuously, out_ready toggling 1,0,1,0 → acks only on out_ready=1 cycles; exactly 4 acks per burst; gnt stays 0x04.
